// File: rtl/alu_bist_if.sv
// alu_bist_if: operand/opcode bus between the BIST controller and the ALU under test.
interface alu_bist_if;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0] alu_control;
  logic [31:0] alu_result;
  modport master(output alu_rs1, alu_rs2, alu_control, input alu_result);
  modport slave(input alu_rs1, alu_rs2, alu_control, output alu_result);
endinterface

// File: rtl/alu_bist.sv
// alu_bist: LFSR-driven ALU self-test, one vector per cycle compacted into a 32-bit MISR.
// Op codes 0..11 are ADD, SUB, LT, LTU, GT, GTU, XOR, OR, AND, SLL, SRL, SRA.
module alu_bist #(
  parameter int PATTERNS = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic abort,
  input logic [31:0] expected_sig,
  alu_bist_if.master alu,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [31:0] signature
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam int PW = PATTERNS > 1 ? $clog2(PATTERNS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, sig_q, sig_d, rs1_q, rs1_d, rs2_q, rs2_d, lfsr_nx;
  logic [3:0] op_q, op_d, ctl_q, ctl_d;
  logic [PW-1:0] pat_q, pat_d;
  logic pass_q, pass_d, pat_last, op_last;
  function automatic logic [31:0] mix(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_5A5A;
  endfunction
  assign lfsr_nx = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? 32'h0040_0007 : 32'h0);
  assign pat_last = pat_q == PW'(PATTERNS - 1);
  assign op_last = op_q == OP_SRA;
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    sig_d = sig_q;
    pass_d = pass_q;
    pat_d = pat_q;
    op_d = op_q;
    rs1_d = '0;
    rs2_d = '0;
    ctl_d = OP_ADD;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        lfsr_d = LFSR_SEED;
        sig_d = '0;
        pass_d = 1'b0;
        pat_d = '0;
        op_d = OP_ADD;
        rs1_d = LFSR_SEED;
        rs2_d = mix(LFSR_SEED);
      end
      RUN: if (abort) state_d = IDLE;
      else begin
        // the result on the bus belongs to the vector currently driven
        sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? 32'h04C1_1DB7 : '0) ^ alu.alu_result;
        if (pat_last && op_last) state_d = DONE;
        else begin
          pat_d = pat_last ? '0 : pat_q + 1'b1;
          op_d = pat_last ? op_q + 4'd1 : op_q;
          lfsr_d = lfsr_nx;
          rs1_d = lfsr_nx;
          rs2_d = mix(lfsr_nx);
          ctl_d = op_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        pass_d = sig_q == expected_sig;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      sig_q <= '0;
      pass_q <= 1'b0;
      pat_q <= '0;
      op_q <= OP_ADD;
      rs1_q <= '0;
      rs2_q <= '0;
      ctl_q <= OP_ADD;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      sig_q <= sig_d;
      pass_q <= pass_d;
      pat_q <= pat_d;
      op_q <= op_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      ctl_q <= ctl_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign signature = sig_q;
  assign alu.alu_rs1 = rs1_q;
  assign alu.alu_rs2 = rs2_q;
  assign alu.alu_control = ctl_q;
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: two BIST instances (PATTERNS=1 and 16) against a bench ALU and a behavioural model.
module tb_alu_bist;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [3:0] c;} vec_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [31:0] exp1 = 0, exp16 = 0, sig1, sig16, s1, s16;
  logic busy1, done1, pass1, busy16, done16, pass16;
  int mode = 0, checks = 0, failures = 0;
  vec_t tab [2][192];
  int n [2], ptr [2];
  bit fin [2];
  alu_bist_if if1();
  alu_bist_if if16();
  always #5 clk = ~clk;
  function automatic logic [31:0] mix(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [31:0] step(input logic [31:0] x);
    return (x << 1) ^ (x[31] ? 32'h0040_0007 : 32'h0);
  endfunction
  // mode 0: stub 0, 1: stub 1, 2: real ALU, 3: real ALU with SRA bit 0 stuck inverted
  function automatic logic [31:0] alu_fn(input int m, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = {31'b0, $signed(a) < $signed(b)};
      4'd3: r = {31'b0, a < b};
      4'd4: r = {31'b0, $signed(a) > $signed(b)};
      4'd5: r = {31'b0, a > b};
      4'd6: r = a ^ b;
      4'd7: r = a | b;
      4'd8: r = a & b;
      4'd9: r = a << b[4:0];
      4'd10: r = a >> b[4:0];
      4'd11: r = $signed(a) >>> b[4:0];
      default: r = 32'h0;
    endcase
    if (m == 3 && c == 4'd11) r[0] = ~r[0];
    return m == 0 ? 32'h0 : m == 1 ? 32'h1 : r;
  endfunction
  assign if1.alu_result = alu_fn(mode, if1.alu_rs1, if1.alu_rs2, if1.alu_control);
  assign if16.alu_result = alu_fn(mode, if16.alu_rs1, if16.alu_rs2, if16.alu_control);
  alu_bist #(.PATTERNS(1)) u_p1 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected_sig(exp1), .alu(if1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));
  alu_bist u_p16 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected_sig(exp16), .alu(if16), .busy(busy16), .done(done16), .pass(pass16), .signature(sig16));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] model_sig(input int p, input int m);
    logic [31:0] l = SEED, s = 0;
    for (int o = 0; o < 12; o++)
      for (int k = 0; k < p; k++) begin
        s = (s << 1) ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ alu_fn(m, l, mix(l), 4'(o));
        l = step(l);
      end
    return s;
  endfunction
  function automatic void gen(input int d, input int p);
    logic [31:0] l = SEED;
    for (int o = 0; o < 12; o++)
      for (int k = 0; k < p; k++) begin
        tab[d][o*p+k] = '{a: l, b: mix(l), c: 4'(o)};
        l = step(l);
      end
    n[d] = 12 * p;
    ptr[d] = 0;
    fin[d] = 0;
  endfunction
  function automatic void clear();
    for (int d = 0; d < 2; d++) begin
      n[d] = 0;
      ptr[d] = 0;
      fin[d] = 0;
    end
  endfunction
  task automatic cyc(input int d, input logic b, input logic dn, input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] c);
    if (ptr[d] < n[d]) begin
      chk($sformatf("busy_run[%0d]", d), {31'b0, b}, 32'd1);
      chk($sformatf("rs1[%0d] v%0d", d, ptr[d]), r1, tab[d][ptr[d]].a);
      chk($sformatf("rs2[%0d] v%0d", d, ptr[d]), r2, tab[d][ptr[d]].b);
      chk($sformatf("ctl[%0d] v%0d", d, ptr[d]), {28'b0, c}, {28'b0, tab[d][ptr[d]].c});
      chk($sformatf("done_run[%0d]", d), {31'b0, dn}, 32'd0);
      ptr[d]++;
      fin[d] = ptr[d] == n[d];
    end else begin
      chk($sformatf("busy_idle[%0d]", d), {31'b0, b}, 32'd0);
      chk($sformatf("done[%0d]", d), {31'b0, dn}, {31'b0, fin[d]});
      chk($sformatf("rs1_idle[%0d]", d), r1, 32'd0);
      chk($sformatf("rs2_idle[%0d]", d), r2, 32'd0);
      chk($sformatf("ctl_idle[%0d]", d), {28'b0, c}, 32'd0);
      fin[d] = 0;
    end
  endtask
  always @(negedge clk) begin
    cyc(0, busy1, done1, if1.alu_rs1, if1.alu_rs2, if1.alu_control);
    cyc(1, busy16, done16, if16.alu_rs1, if16.alu_rs2, if16.alu_control);
  end
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, " busy1"}, {31'b0, busy1}, 0);
    chk({tag, " done1"}, {31'b0, done1}, 0);
    chk({tag, " pass1"}, {31'b0, pass1}, 0);
    chk({tag, " sig1"}, sig1, 0);
    chk({tag, " rs1_1"}, if1.alu_rs1, 0);
    chk({tag, " rs2_1"}, if1.alu_rs2, 0);
    chk({tag, " ctl_1"}, {28'b0, if1.alu_control}, 0);
    chk({tag, " busy16"}, {31'b0, busy16}, 0);
    chk({tag, " done16"}, {31'b0, done16}, 0);
    chk({tag, " pass16"}, {31'b0, pass16}, 0);
    chk({tag, " sig16"}, sig16, 0);
    chk({tag, " rs1_16"}, if16.alu_rs1, 0);
    chk({tag, " rs2_16"}, if16.alu_rs2, 0);
    chk({tag, " ctl_16"}, {28'b0, if16.alu_control}, 0);
  endtask
  task automatic start_run();
    tick(1);
    start = 1;
    tick(1);
    start = 0;
    gen(0, 1);
    gen(1, 16);
  endtask
  task automatic wait_end();
    int k = 0;
    while (!(ptr[0] == n[0] && ptr[1] == n[1] && !fin[0] && !fin[1]) && k < 400) begin
      tick(1);
      k++;
    end
    checks++;
    if (k >= 400) begin
      failures++;
      $display("FAIL run_timeout: got %0d cycles required below 400", k);
    end
    tick(1);
  endtask
  initial begin
    #1 reset_vals("reset");
    #12 rst_n = 1;
    // stub 0: all-zero signature, first vector pinned to literals
    mode = 0;
    start_run();
    chk("vec0_rs1", if1.alu_rs1, 32'hACE1_2468);
    chk("vec0_rs2", if1.alu_rs2, 32'h7E32_F6BB);
    chk("vec0_ctl", {28'b0, if1.alu_control}, 0);
    wait_end();
    chk("zero_sig1", sig1, 0);
    chk("zero_pass1", {31'b0, pass1}, 1);
    chk("zero_sig16", sig16, 0);
    chk("zero_pass16", {31'b0, pass16}, 1);
    // stub 1
    mode = 1;
    exp1 = 32'h0000_0FFF;
    exp16 = model_sig(16, 1);
    chk("model_const1", model_sig(1, 1), 32'h0000_0FFF);
    start_run();
    wait_end();
    chk("one_sig1", sig1, 32'h0000_0FFF);
    chk("one_pass1", {31'b0, pass1}, 1);
    chk("one_pass16", {31'b0, pass16}, 1);
    exp1 = 32'h0000_0FFE;
    start_run();
    wait_end();
    chk("one_bad_sig1", sig1, 32'h0000_0FFF);
    chk("one_bad_pass1", {31'b0, pass1}, 0);
    // real ALU
    mode = 2;
    exp1 = model_sig(1, 2);
    exp16 = model_sig(16, 2);
    start_run();
    wait_end();
    chk("real_sig1", sig1, model_sig(1, 2));
    chk("real_pass1", {31'b0, pass1}, 1);
    chk("real_sig16", sig16, model_sig(16, 2));
    chk("real_pass16", {31'b0, pass16}, 1);
    // abort on RUN cycle 5
    start_run();
    tick(4);
    abort = 1;
    s1 = sig1;
    s16 = sig16;
    tick(1);
    abort = 0;
    clear();
    chk("abort_busy16", {31'b0, busy16}, 0);
    chk("abort_pass16", {31'b0, pass16}, 0);
    chk("abort_sig16", sig16, s16);
    chk("abort_sig1", sig1, s1);
    tick(5);
    chk("abort_sig16_later", sig16, s16);
    // start re-pulsed mid-run is ignored
    start_run();
    tick(6);
    start = 1;
    tick(1);
    start = 0;
    wait_end();
    chk("restart_sig16", sig16, model_sig(16, 2));
    chk("restart_pass16", {31'b0, pass16}, 1);
    // asynchronous reset between edges
    start_run();
    tick(3);
    @(posedge clk);
    #2 rst_n = 0;
    #1 reset_vals("midrst");
    clear();
    tick(2);
    rst_n = 1;
    start_run();
    wait_end();
    chk("post_rst_sig16", sig16, model_sig(16, 2));
    chk("post_rst_pass16", {31'b0, pass16}, 1);
    chk("post_rst_sig1", sig1, model_sig(1, 2));
    // faulty SRA path
    mode = 3;
    start_run();
    wait_end();
    chk("fault_sig16", sig16, model_sig(16, 3));
    chk("fault_pass16", {31'b0, pass16}, 0);
    chk("fault_pass1", {31'b0, pass1}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
